// File: rtl/exec_seq_ctrl.sv
// Multi-cycle fetch/execute/memory sequencer for the RV32E core.
// Owns the instruction register, the retire counter and the sticky halt/error flags.
module exec_seq_ctrl #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ifu_req_valid,
  input  logic        ifu_req_ready,
  input  logic        ifu_rsp_valid,
  input  logic [31:0] ifu_rsp_inst,
  input  logic        ifu_rsp_err,
  output logic [31:0] inst,
  input  logic        is_load,
  input  logic        is_store,
  input  logic        is_ebreak,
  output logic        lsu_req_valid,
  input  logic        lsu_req_ready,
  input  logic        lsu_rsp_valid,
  input  logic        lsu_rsp_err,
  output logic        pc_we,
  output logic        rf_we,
  output logic        halt,
  output logic        error,
  output logic [2:0]  state,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    FETCH_REQ  = 3'd1,
    FETCH_WAIT = 3'd2,
    EXEC       = 3'd3,
    MEM_REQ    = 3'd4,
    MEM_WAIT   = 3'd5,
    WB         = 3'd6,
    STOP       = 3'd7
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] instret_q, instret_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        halt_q, halt_d;
  logic        error_q, error_d;
  logic        wait_expired;

  // The counter holds the number of cycles already waited; this cycle is the last allowed one.
  assign wait_expired = (wait_cnt_q + 8'd1) == TIMEOUT;

  always_comb begin
    state_d       = state_q;
    inst_d        = inst_q;
    instret_d     = instret_q;
    wait_cnt_d    = wait_cnt_q;
    halt_d        = halt_q;
    error_d       = error_q;
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    pc_we         = 1'b0;
    rf_we         = 1'b0;

    case (state_q)
      IDLE: state_d = FETCH_REQ;

      FETCH_REQ: begin
        ifu_req_valid = 1'b1;
        if (ifu_req_ready) begin
          wait_cnt_d = 8'd0;
          state_d    = FETCH_WAIT;
        end
      end

      FETCH_WAIT: begin
        // A response always beats an expiring timeout in the same cycle.
        if (ifu_rsp_valid) begin
          if (ifu_rsp_err) begin
            error_d = 1'b1;
            state_d = STOP;
          end else begin
            inst_d  = ifu_rsp_inst;
            state_d = EXEC;
          end
        end else if (wait_expired) begin
          error_d = 1'b1;
          state_d = STOP;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end

      EXEC: begin
        if (is_ebreak) begin
          halt_d  = 1'b1;
          state_d = STOP;
        end else if (is_load || is_store) begin
          state_d = MEM_REQ;
        end else begin
          state_d = WB;
        end
      end

      MEM_REQ: begin
        lsu_req_valid = 1'b1;
        if (lsu_req_ready) begin
          wait_cnt_d = 8'd0;
          state_d    = MEM_WAIT;
        end
      end

      MEM_WAIT: begin
        if (lsu_rsp_valid) begin
          if (lsu_rsp_err) begin
            error_d = 1'b1;
            state_d = STOP;
          end else begin
            state_d = WB;
          end
        end else if (wait_expired) begin
          error_d = 1'b1;
          state_d = STOP;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end

      WB: begin
        pc_we     = 1'b1;
        rf_we     = !is_store;
        instret_d = instret_q + 32'd1;
        state_d   = FETCH_REQ;
      end

      STOP: state_d = STOP;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      inst_q     <= 32'h0;
      instret_q  <= 32'd0;
      wait_cnt_q <= 8'd0;
      halt_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      inst_q     <= inst_d;
      instret_q  <= instret_d;
      wait_cnt_q <= wait_cnt_d;
      halt_q     <= halt_d;
      error_q    <= error_d;
    end
  end

  assign inst    = inst_q;
  assign instret = instret_q;
  assign halt    = halt_q;
  assign error   = error_q;
  assign state   = state_q;

endmodule

// File: tb/tb_exec_seq_ctrl.sv
// Directed bench for exec_seq_ctrl: stimulus pushes expected retire/stop events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_exec_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_err;
  logic [31:0] ifu_rsp_inst, inst, instret;
  logic        is_load, is_store, is_ebreak;
  logic        lsu_req_valid, lsu_req_ready, lsu_rsp_valid, lsu_rsp_err;
  logic        pc_we, rf_we, halt, error;
  logic [2:0]  state;

  localparam logic [31:0] I_ADDI1  = 32'h00100093;
  localparam logic [31:0] I_ADDI2  = 32'h00200113;
  localparam logic [31:0] I_ADDI3  = 32'h00300193;
  localparam logic [31:0] I_SW     = 32'h00112023;
  localparam logic [31:0] I_LW     = 32'h00012083;
  localparam logic [31:0] I_EBREAK = 32'h00100073;

  exec_seq_ctrl #(.TIMEOUT(8'd4)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_inst(ifu_rsp_inst), .ifu_rsp_err(ifu_rsp_err),
    .inst(inst), .is_load(is_load), .is_store(is_store), .is_ebreak(is_ebreak),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_err(lsu_rsp_err),
    .pc_we(pc_we), .rf_we(rf_we), .halt(halt), .error(error),
    .state(state), .instret(instret)
  );

  always #5 clk = ~clk;

  // Minimal decoder model standing in for the idu.
  always_comb begin
    is_load   = (inst[6:0] == 7'b0000011);
    is_store  = (inst[6:0] == 7'b0100011);
    is_ebreak = (inst == I_EBREAK);
  end

  typedef struct packed {
    logic        stop;
    logic        rf_we;
    logic        halt;
    logic        error;
    logic [31:0] inst;
    logic [31:0] instret;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push_retire(input logic rf, input logic [31:0] w, input logic [31:0] n);
    exp_t e;
    e = '{stop: 1'b0, rf_we: rf, halt: 1'b0, error: 1'b0, inst: w, instret: n};
    sb_q.push_back(e);
  endtask

  task automatic push_stop(input logic h, input logic er, input logic [31:0] n);
    exp_t e;
    e = '{stop: 1'b1, rf_we: 1'b0, halt: h, error: er, inst: 32'h0, instret: n};
    sb_q.push_back(e);
  endtask

  // Monitor: retire on pc_we, stop on entry to state 7.
  logic [2:0] prev_state = 3'd0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_state = 3'd0;
    end else begin
      chk("halt_error_exclusive", {71'd0, halt & error}, 72'd0);
      if (pc_we) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_retire", {40'd0, inst}, 72'd0);
        end else begin
          e = sb_q.pop_front();
          $display("retire inst=%08h rf_we=%0d instret=%0d", inst, rf_we, instret);
          chk("retire", {6'd0, 1'b0, rf_we, inst, instret},
                        {6'd0, e.stop, e.rf_we, e.inst, e.instret});
        end
      end
      if (state == 3'd7 && prev_state != 3'd7) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_stop", {70'd0, halt, error}, 72'd0);
        end else begin
          e = sb_q.pop_front();
          $display("stop halt=%0d error=%0d instret=%0d", halt, error, instret);
          chk("stop", {37'd0, 1'b1, halt, error, instret},
                      {37'd0, e.stop, e.halt, e.error, e.instret});
        end
      end
      prev_state = state;
    end
  end

  // One clock; checks state and the state-decoded request/enable outputs.
  task automatic cyc(input logic [2:0] es);
    @(posedge clk); #1;
    chk("state_outputs", {66'd0, state, ifu_req_valid, lsu_req_valid, pc_we},
                         {66'd0, es, es == 3'd1, es == 3'd4, es == 3'd6});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(3'd0);
    chk("reset_regs", {6'd0, inst, instret, halt, error}, 72'd0);
    rst = 1'b0;
  endtask

  // From FETCH_REQ: accept at once, respond next cycle, land in EXEC.
  task automatic fetch(input logic [31:0] w);
    ifu_req_ready = 1'b1;
    cyc(3'd2);
    ifu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b1;
    ifu_rsp_inst  = w;
    cyc(3'd3);
    ifu_rsp_valid = 1'b0;
    chk("inst_reg", {40'd0, inst}, {40'd0, w});
  endtask

  // Zero-wait load from FETCH_REQ back to FETCH_REQ; a same-cycle error response is ignored.
  task automatic load_ok(input logic [31:0] n);
    push_retire(1'b1, I_LW, n);
    fetch(I_LW);
    cyc(3'd4);
    lsu_req_ready = 1'b1;
    lsu_rsp_valid = 1'b1;
    lsu_rsp_err   = 1'b1;
    cyc(3'd5);
    lsu_req_ready = 1'b0;
    lsu_rsp_err   = 1'b0;
    cyc(3'd6);
    lsu_rsp_valid = 1'b0;
    chk("load_rf_we", {71'd0, rf_we}, 72'd1);
    cyc(3'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b0; ifu_rsp_err = 1'b0; ifu_rsp_inst = 32'h0;
    lsu_req_ready = 1'b0; lsu_rsp_valid = 1'b0; lsu_rsp_err = 1'b0;
    do_reset();

    // addi, zero-wait: states 0,1,2,3,6,1
    cyc(3'd1);
    push_retire(1'b1, I_ADDI1, 32'd0);
    fetch(I_ADDI1);
    cyc(3'd6);
    chk("addi_rf_we", {71'd0, rf_we}, 72'd1);
    cyc(3'd1);
    chk("instret_after_addi", {40'd0, instret}, 72'd1);

    // fetch ready withheld for 3 cycles
    repeat (3) cyc(3'd1);
    push_retire(1'b1, I_ADDI2, 32'd1);
    fetch(I_ADDI2);
    cyc(3'd6);
    cyc(3'd1);
    chk("instret_after_stall", {40'd0, instret}, 72'd2);

    // store, lsu response after 2 wait cycles
    push_retire(1'b0, I_SW, 32'd2);
    fetch(I_SW);
    cyc(3'd4);
    lsu_req_ready = 1'b1;
    cyc(3'd5);
    lsu_req_ready = 1'b0;
    cyc(3'd5);
    cyc(3'd5);
    lsu_rsp_valid = 1'b1;
    cyc(3'd6);
    lsu_rsp_valid = 1'b0;
    chk("store_rf_we", {71'd0, rf_we}, 72'd0);
    cyc(3'd1);

    // fetch response on the last allowed wait cycle wins over timeout
    push_retire(1'b1, I_ADDI3, 32'd3);
    ifu_req_ready = 1'b1;
    cyc(3'd2);
    ifu_req_ready = 1'b0;
    cyc(3'd2); cyc(3'd2); cyc(3'd2);
    ifu_rsp_valid = 1'b1;
    ifu_rsp_inst  = I_ADDI3;
    cyc(3'd3);
    ifu_rsp_valid = 1'b0;
    cyc(3'd6);
    cyc(3'd1);

    // fetch timeout after 4 wait cycles
    push_stop(1'b0, 1'b1, 32'd4);
    ifu_req_ready = 1'b1;
    cyc(3'd2);
    ifu_req_ready = 1'b0;
    cyc(3'd2); cyc(3'd2); cyc(3'd2);
    cyc(3'd7);
    chk("timeout_error", {70'd0, halt, error}, 72'd1);
    ifu_rsp_valid = 1'b1;
    ifu_rsp_inst  = I_EBREAK;
    cyc(3'd7);
    ifu_rsp_valid = 1'b0;
    chk("late_rsp_ignored", {40'd0, inst}, {40'd0, I_ADDI3});
    cyc(3'd7);
    do_reset();

    // ebreak halts without retiring
    cyc(3'd1);
    push_stop(1'b1, 1'b0, 32'd0);
    fetch(I_EBREAK);
    cyc(3'd7);
    chk("ebreak_halt", {38'd0, halt, error, instret}, {38'd0, 2'b10, 32'd0});
    cyc(3'd7); cyc(3'd7);
    do_reset();

    // load ok, then load with bus error
    cyc(3'd1);
    load_ok(32'd0);
    chk("instret_after_load", {40'd0, instret}, 72'd1);
    push_stop(1'b0, 1'b1, 32'd1);
    fetch(I_LW);
    cyc(3'd4);
    lsu_req_ready = 1'b1;
    cyc(3'd5);
    lsu_req_ready = 1'b0;
    lsu_rsp_valid = 1'b1;
    lsu_rsp_err   = 1'b1;
    cyc(3'd7);
    lsu_rsp_valid = 1'b0;
    lsu_rsp_err   = 1'b0;
    chk("load_err", {70'd0, rf_we, error}, 72'd1);
    cyc(3'd7);
    do_reset();

    // reset while waiting for a load response
    cyc(3'd1);
    load_ok(32'd0);
    fetch(I_LW);
    cyc(3'd4);
    lsu_req_ready = 1'b1;
    cyc(3'd5);
    lsu_req_ready = 1'b0;
    rst = 1'b1;
    cyc(3'd0);
    chk("reset_in_mem_wait", {40'd0, instret}, 72'd0);
    rst = 1'b0;
    cyc(3'd1);

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_drained", {40'd0, sb_q.size()}, 72'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/exec_seq_ctrl.md
# exec_seq_ctrl

Multi-cycle sequencer for the RV32E core. Sits beside the regf/idu/exu datapath in the top level. Fetches each instruction over a valid/ready handshake, holds it in an instruction register for the decoder, and sequences optional load/store memory access. Issues exactly one PC update and at most one register-file write per retired instruction, halts on ebreak, and traps bus errors and timeouts.

## Interface
Parameters:
- TIMEOUT, 8'd255: maximum cycles allowed in FETCH_WAIT or MEM_WAIT before the block declares an error; legal range 1–255.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- ifu_req_valid  out  1  fetch request, address is the current pc.
- ifu_req_ready  in  1  fetch request accepted.
- ifu_rsp_valid  in  1  fetch data valid.
- ifu_rsp_inst  in  32  fetched instruction.
- ifu_rsp_err  in  1  fetch bus error; qualified by ifu_rsp_valid.
- inst  out  32  instruction register, fed to the decoder.
- is_load  in  1  decoder: current inst is a load.
- is_store  in  1  decoder: current inst is a store.
- is_ebreak  in  1  decoder: current inst is ebreak.
- lsu_req_valid  out  1  data-memory request.
- lsu_req_ready  in  1  data request accepted.
- lsu_rsp_valid  in  1  data response valid.
- lsu_rsp_err  in  1  data bus error; qualified by lsu_rsp_valid.
- pc_we  out  1  one-cycle pulse: pc loads next-pc.
- rf_we  out  1  one-cycle pulse: register-file write enable.
- halt  out  1  sticky; ebreak retired.
- error  out  1  sticky; bus error or timeout.
- state  out  3  current state encoding, for debug.
- instret  out  32  retired-instruction counter.

## Operation
States and encodings: IDLE=0, FETCH_REQ=1, FETCH_WAIT=2, EXEC=3, MEM_REQ=4, MEM_WAIT=5, WB=6, STOP=7.

Transitions:
- IDLE → FETCH_REQ unconditionally.
- FETCH_REQ: ifu_req_valid=1. Goes to FETCH_WAIT when ifu_req_ready=1. Valid stays high until accepted.
- FETCH_WAIT: when ifu_rsp_valid=1:
  - if ifu_rsp_err=1 → STOP with error=1;
  - otherwise inst ← ifu_rsp_inst and → EXEC.
- EXEC (decoder and ALU settle), evaluated in priority order:
  1. is_ebreak → STOP with halt=1. No pc_we, no rf_we.
  2. is_load or is_store → MEM_REQ.
  3. otherwise → WB.
- MEM_REQ: lsu_req_valid=1. Goes to MEM_WAIT when lsu_req_ready=1.
- MEM_WAIT: when lsu_rsp_valid=1:
  - if lsu_rsp_err=1 → STOP with error=1;
  - otherwise → WB.
- WB:
  - pc_we=1;
  - rf_we = !is_store;
  - instret += 1, wrapping at 2^32;
  - → FETCH_REQ.
- STOP: absorbing; only rst leaves it. All request and enable outputs are 0.

Timeout:
- An 8-bit wait counter clears on entry to FETCH_WAIT or MEM_WAIT and increments each cycle spent waiting.
- Reaching TIMEOUT without a response → STOP with error=1.

Other rules:
- Responses arriving outside the WAIT states are ignored.
- inst holds its value outside FETCH_WAIT.
- is_* inputs are sampled only in EXEC and WB.

## Timing
Reset:
- When rst is high at a clock edge: state=IDLE, inst=32'h0, instret=0, wait counter=0, halt=0, error=0.
- All request and enable outputs are combinational decodes of state, so they are 0 in IDLE.
- Reset asserted mid-transaction abandons it. The same-cycle request is not retracted externally; the memory model must tolerate this.

Latency:
- Zero-wait non-memory instruction: FETCH_REQ, FETCH_WAIT, EXEC, WB = 4 cycles per instruction. pc_we asserts in the 4th cycle.
- Zero-wait load/store: 6 cycles per instruction.
- Earliest response is the cycle after request acceptance. A response in the same cycle as acceptance is not sampled.

Simultaneous events:
- Response and timeout in the same cycle: the response wins.
- is_ebreak together with is_load: ebreak wins.
- rsp_valid with rsp_err: error wins; inst is not updated.

Outputs:
- pc_we and rf_we are never high outside WB.
- halt and error are never both set.

## Test plan
- Reset release, ready=1, 1-cycle response with 32'h00100093 (addi): pc_we high in cycle 4 only, rf_we=1, instret=1, state sequence 0,1,2,3,6,1.
- ifu_req_ready held low 3 cycles: ifu_req_valid stays high throughout, FETCH_WAIT entered on the 4th cycle, no pc_we before the response.
- Store 32'h00112023 with lsu response after 2 wait cycles: lsu_req_valid for 1 cycle, WB reached, pc_we=1, rf_we=0, 8 cycles total.
- Fetch response withheld with TIMEOUT=4: error=1 and state=7 after 4 FETCH_WAIT cycles; a later ifu_rsp_valid is ignored; rst returns state=0 and error=0.
- Fetch of ebreak 32'h00100073: halt=1, state=7, instret unchanged, pc_we never asserted.
- lsu_rsp_valid with lsu_rsp_err=1 on a load: error=1, no rf_we; reset asserted in MEM_WAIT → state=0, instret=0 next cycle.
